// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_port data-memory responder:
// FSM state encoding, access-width encoding and lane/extension functions.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } width_e;

    // w beats h beats b; no width bit at all means a word access.
    function automatic width_e decode_width(input logic b, input logic h, input logic w);
        if (w) begin
            return WORD;
        end else if (h) begin
            return HALF;
        end else if (b) begin
            return BYTE;
        end else begin
            return WORD;
        end
    endfunction

    function automatic logic [3:0] lane_en(input width_e wd, input logic [1:0] lo);
        case (wd)
            BYTE:    return 4'b0001 << lo;
            HALF:    return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_rep(input width_e wd, input logic [31:0] d);
        case (wd)
            BYTE:    return {4{d[7:0]}};
            HALF:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input width_e wd, input logic uns,
                                             input logic [1:0] lo, input logic [31:0] word);
        logic [7:0]  bsel;
        logic [15:0] hsel;
        bsel = 8'(word >> {lo, 3'b000});
        hsel = 16'(word >> {lo[1], 4'b0000});
        case (wd)
            BYTE:    return uns ? {24'd0, bsel} : {{24{bsel[7]}}, bsel};
            HALF:    return uns ? {16'd0, hsel} : {{16{hsel[15]}}, hsel};
            default: return word;
        endcase
    endfunction

    function automatic logic misaligned(input width_e wd, input logic [1:0] lo);
        case (wd)
            HALF:    return lo[0];
            WORD:    return lo != 2'd0;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised synchronous single-port RAM with per-byte write enables
// and a registered read port. Contents are not reset.
module dmem_byte_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [3:0]       i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_q;

    // Read returns the pre-write contents of the addressed word.
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i_we[i]) begin
                    r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
            r_q <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/dmem_port.sv
// MEM-stage load/store responder: IDLE -> BUSY -> DONE with fixed 2-cycle latency.
// Optional misalignment checking is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_port
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic        b,
    input  logic        h,
    input  logic        w,
    input  logic        bhu,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall,
    output logic        misalign
);

    state_e           r_state;
    state_e           w_next;
    logic             w_req;
    logic             w_mis;
    logic [3:0]       w_we;
    logic [31:0]      w_ram_q;
    logic             w_unused;

    logic [IDX_W+1:0] r_addr;
    logic [31:0]      r_wdata;
    width_e           r_width;
    logic             r_bhu;
    logic             r_store;

    width_e           r_o_width;
    logic [1:0]       r_o_lo;
    logic             r_o_bhu;
    logic             r_o_ld;
    logic             r_o_mis;

    assign w_req    = mem_read_i | mem_write_i;
    assign w_unused = ^addr[31:IDX_W+2];

`ifdef DMEM_MISALIGN_CHK_EN
    assign w_mis = misaligned(r_width, r_addr[1:0]);
`else
    assign w_mis = 1'b0;
`endif

    // Only the BUSY cycle touches the RAM; a misaligned store writes no lanes.
    assign w_we = (r_state == ST_BUSY && r_store && !w_mis) ? lane_en(r_width, r_addr[1:0]) : 4'b0000;

    dmem_byte_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk    (clk),
        .i_en   (r_state == ST_BUSY),
        .i_we   (w_we),
        .i_idx  (r_addr[IDX_W+1:2]),
        .i_wdata(store_rep(r_width, r_wdata)),
        .o_rdata(w_ram_q)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; requests are only recognised in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next = ST_BUSY;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_BUSY: w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Request capture; a simultaneous read+write is treated as a store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_width <= WORD;
            r_bhu   <= 1'b0;
            r_store <= 1'b0;
        end else if (r_state == ST_IDLE && w_req) begin
            r_addr  <= addr[IDX_W+1:0];
            r_wdata <= wdata;
            r_width <= decode_width(b, h, w);
            r_bhu   <= bhu;
            r_store <= mem_write_i;
        end
    end

    // Result context, aligned with the RAM read register so rdata holds until the next DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o_width <= WORD;
            r_o_lo    <= 2'd0;
            r_o_bhu   <= 1'b0;
            r_o_ld    <= 1'b0;
            r_o_mis   <= 1'b0;
        end else if (r_state == ST_BUSY) begin
            r_o_width <= r_width;
            r_o_lo    <= r_addr[1:0];
            r_o_bhu   <= r_bhu;
            r_o_ld    <= !r_store && !w_mis;
            r_o_mis   <= w_mis;
        end
    end

    assign rdata    = r_o_ld ? load_ext(r_o_width, r_o_bhu, r_o_lo, w_ram_q) : 32'd0;
    assign ready    = (r_state == ST_DONE);
    assign misalign = ready & r_o_mis;
    assign stall    = w_req & (r_state != ST_DONE);

endmodule

// File: doc/dmem_port.md
# dmem_port

Data-memory responder for the load/store control bundle produced by the instruction decoder (`mem_read_i`, `mem_write_i`, `b`, `h`, `w`, `bhu`).
- Owns a word-organised synchronous RAM.
- Performs byte, half and word stores through byte enables, and sign- or zero-extended loads.
- Holds the pipeline with `stall` until each access completes.
- Sits in the MEM stage, between the ALU result/rs2 path and the write-back mux.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `IDX_W`, $clog2(DEPTH_WORDS): word-index width; derived, not overridden.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_read_i` in 1: load request.
- `mem_write_i` in 1: store request.
- `b`, `h`, `w` in 1 each: access width (byte, half, word).
- `bhu` in 1: unsigned load (zero-extend).
- `addr` in 32: byte address.
- `wdata` in 32: store data; the value is taken from the low bits.
- `rdata` out 32: load result, valid while `ready`=1.
- `ready` out 1: one-cycle pulse marking completion of the access.
- `stall` out 1: request pending and not yet complete.
- `misalign` out 1: pulses with `ready` when the access was misaligned (see Configuration).

## Operation
- Request = `mem_read_i` | `mem_write_i`.
  - If both are asserted, the store wins and `rdata`=0.
- Width priority is `w` > `h` > `b`. A request with no width bit set is treated as a word access.
- State machine (encoding in the package):
  - IDLE:
    - On a request, latch `addr`, `wdata`, width, `bhu` and direction, then go to BUSY.
    - With no request, stay in IDLE.
  - BUSY:
    - Present the RAM access.
    - A store commits its byte enables on the edge that leaves BUSY.
    - A load captures the addressed word on that same edge.
    - Go to DONE.
  - DONE:
    - `ready`=1 and `rdata` is driven; go to IDLE.
    - A request still asserted in DONE belongs to the instruction completing now and is not re-issued. A new request is recognised only in IDLE.
- Byte lanes:
  - `b`: lane `addr[1:0]`.
  - `h`: lanes {`addr[1]`,0} and {`addr[1]`,1}.
  - `w`: all four lanes.
  - Store data is replicated into the active lanes from `wdata[7:0]` or `wdata[15:0]`.
- Loads:
  - The selected byte or half is right-justified.
  - It is sign-extended from bit 7 or bit 15, or zero-extended when `bhu`=1.
  - `bhu` with `w` is ignored.
- Word index = `addr[IDX_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS×4.
- `stall` = request & (state != DONE).
- Reset values: state IDLE; `ready`, `stall` (when no request), `misalign` and `rdata` are all 0. RAM contents are not reset.
- Reset mid-operation:
  - Asserted in BUSY: the store is aborted with no RAM write, and the state returns to IDLE.
  - Asserted in DONE: `ready` drops immediately.

## Timing
- Request first seen in IDLE at cycle 0 → BUSY at cycle 1 → `ready` at cycle 2.
  - Fixed latency of 2 cycles.
  - `stall` is high during cycles 0–1 and low at cycle 2.
- Back-to-back requests: the next request is accepted no earlier than the cycle after DONE (3-cycle issue interval).
- Request inputs must be held stable while `stall`=1. Only the values latched in IDLE are used.
- `rdata` is registered and holds its value until the next DONE.

## Configuration
- `DMEM_MISALIGN_CHK_EN` defined:
  - Misaligned means `h` with `addr[0]`=1, or `w` with `addr[1:0]`≠0.
  - A misaligned store writes nothing.
  - A misaligned load returns `rdata`=0.
  - `misalign`=1 in DONE. Latency is unchanged.
- Not defined:
  - Offending low address bits are ignored: `h` uses `addr[1]` only, `w` uses the word index only.
  - `misalign` is tied to 0.

## Structure
- Package `dmem_pkg`:
  - State enum {IDLE, BUSY, DONE}.
  - Width encoding constants (BYTE, HALF, WORD).
  - Lane-enable and extension helper functions.
- Sub-module `dmem_byte_ram`: synchronous single-port RAM with a 4-bit byte-write enable and a registered read port. The FSM, lane steering and extension logic stay in `dmem_port`.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10 → `ready` 2 cycles after each request; `rdata`=0xDEADBEEF; `stall` high for exactly 2 cycles per access.
- SB 0x80 to 0x13 over word 0x00000000, then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LW 0x10 → 0x80000000.
- SH 0x8001 to 0x22, then LH 0x22 → 0xFFFF8001; LHU → 0x00008001; lanes 0–1 unchanged.
- With the macro: LW 0x11 → `rdata`=0, `misalign`=1. SH to 0x21 leaves memory unchanged. Without the macro: LW 0x11 returns the word at 0x10 and `misalign`=0.
- Assert `rst` during BUSY of SW 0x12345678 to 0x30 → no `ready`; state returns to IDLE; LW 0x30 returns the prior contents.
- `mem_read_i` and `mem_write_i` both asserted with SW 0xA5A5A5A5 to 0x40 → store committed, `rdata`=0. Address 0x40 + DEPTH_WORDS×4 aliases to 0x40.
